// File: rtl/alu_muldiv_control.sv
// ALU control decode plus iterative multiply/divide sequencer with HI/LO registers.
// Build option: define MULDIV_DIV_EN to include the divider (DIV/DIVU); otherwise divides only pulse done.
module alu_muldiv_control #(
   parameter int WIDTH   = 32,
   parameter int FUNCT_W = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [3:0]         control,
   output logic               stall,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
   localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
   localparam logic [FUNCT_W-1:0] F_JR   = 6'b001000;
   localparam logic [FUNCT_W-1:0] F_MFHI = 6'b010000;
   localparam logic [FUNCT_W-1:0] F_MFLO = 6'b010010;
   localparam logic [FUNCT_W-1:0] F_MULT = 6'b011000;
   localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
   localparam logic [FUNCT_W-1:0] F_ADDU = 6'b100001;
   localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
   localparam logic [FUNCT_W-1:0] F_SUBU = 6'b100011;
   localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
   localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
   localparam logic [FUNCT_W-1:0] F_NOR  = 6'b100111;
   localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;
   localparam logic [FUNCT_W-1:0] F_SLTU = 6'b101011;

`ifdef MULDIV_DIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mq;
   logic [WIDTH-1:0] r_opb;
   logic [CW-1:0]    r_cnt;
   logic             r_sign_p;

   logic               w_is_md;
   logic               w_start_md;
   logic               w_is_div;
   logic               w_signed;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH-1:0]   w_mul_acc_n;
   logic [WIDTH-1:0]   w_mul_mq_n;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;

   assign w_is_md    = (op == 2'b10) && (funct[FUNCT_W-1:2] == F_MULT[FUNCT_W-1:2]);
   assign w_start_md = start & w_is_md;
   assign w_is_div   = funct[1];
   assign w_signed   = ~funct[0];
   assign w_a_mag    = (w_signed & a[WIDTH-1]) ? -a : a;
   assign w_b_mag    = (w_signed & b[WIDTH-1]) ? -b : b;

   // Shift-add step: accumulator gets the multiplicand when the low multiplier bit is set
   assign w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
   assign w_mul_acc_n = w_mul_sum[WIDTH:1];
   assign w_mul_mq_n  = {w_mul_sum[0], r_mq[WIDTH-1:1]};
   assign w_prod      = {w_mul_acc_n, w_mul_mq_n};
   assign w_prod_fix  = r_sign_p ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
   logic             r_sign_r;
   logic [WIDTH:0]   w_div_sh;
   logic [WIDTH:0]   w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_rem_n;
   logic [WIDTH-1:0] w_div_q_n;

   // Restoring step: the top bit of the difference is set exactly when the trial subtract underflows
   assign w_div_sh    = {r_acc, r_mq[WIDTH-1]};
   assign w_div_diff  = w_div_sh - {1'b0, r_opb};
   assign w_div_ge    = ~w_div_diff[WIDTH];
   assign w_div_rem_n = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
   assign w_div_q_n   = {r_mq[WIDTH-2:0], w_div_ge};
`endif

   // ALU operation decode
   always_comb begin
      control = 4'b0000;
      case (op)
         2'b00: control = 4'b0010;
         2'b01: control = 4'b0110;
         2'b10: begin
            case (funct)
               F_ADD, F_ADDU:         control = 4'b0010;
               F_SUB, F_SUBU:         control = 4'b0110;
               F_AND:                 control = 4'b0000;
               F_OR:                  control = 4'b0001;
               F_NOR:                 control = 4'b1100;
               F_SLT, F_SLTU:         control = 4'b0111;
               F_SLL:                 control = 4'b1001;
               F_SRL:                 control = 4'b1010;
               F_JR, F_MFHI, F_MFLO:  control = 4'b0011;
               default:               control = 4'b0000;
            endcase
         end
         default: control = 4'b0000;
      endcase
   end

   // In the done cycle only a new muldiv must wait; MFHI/MFLO already see the fresh HI/LO
   always_comb begin
      stall = r_busy;
      if (start && (r_state == S_DONE) && w_is_md) begin
         stall = 1'b1;
      end else begin
         stall = r_busy;
      end
   end

   // Sequencer: results and done are written on the final iteration edge, so done, HI and LO
   // become visible together in the DONE cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_acc    <= '0;
         r_mq     <= '0;
         r_opb    <= '0;
         r_cnt    <= '0;
         r_sign_p <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_sign_r <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_start_md) begin
                  r_acc    <= '0;
                  r_mq     <= w_a_mag;
                  r_opb    <= w_b_mag;
                  r_cnt    <= '0;
                  r_sign_p <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  if (w_is_div) begin
`ifdef MULDIV_DIV_EN
                     r_sign_r <= w_signed & a[WIDTH-1];
                     if (b == '0) begin
                        r_lo    <= '1;
                        r_hi    <= a;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_busy  <= 1'b1;
                        r_state <= S_DIV;
                     end
`else
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
`endif
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= S_MUL;
                  end
               end
            end
            S_MUL: begin
               r_acc <= w_mul_acc_n;
               r_mq  <= w_mul_mq_n;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo    <= w_prod_fix[WIDTH-1:0];
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
               r_acc <= w_div_rem_n;
               r_mq  <= w_div_q_n;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_lo    <= r_sign_p ? -w_div_q_n : w_div_q_n;
                  r_hi    <= r_sign_r ? -w_div_rem_n : w_div_rem_n;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Randomized self-checking bench for alu_muldiv_control against a plain-arithmetic HI/LO model.
module tb_alu_muldiv_control;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic        start;
   logic [31:0] a, b;
   logic [3:0]  control;
   logic        stall, busy, done;
   logic [31:0] hi, lo;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   localparam logic [5:0] MULT  = 6'b011000;
   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] DIV   = 6'b011010;
   localparam logic [5:0] DIVU  = 6'b011011;
   localparam logic [5:0] MFLO  = 6'b010010;

   alu_muldiv_control #(.WIDTH(32), .FUNCT_W(6)) dut (
      .clock(clock), .reset(reset), .op(op), .funct(funct), .start(start),
      .a(a), .b(b), .control(control), .stall(stall), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   function automatic logic [3:0] ref_ctrl(input logic [1:0] o, input logic [5:0] f);
      if (o == 2'b00) return 4'b0010;
      if (o == 2'b01) return 4'b0110;
      if (o == 2'b11) return 4'b0000;
      case (f)
         6'b100000, 6'b100001: return 4'b0010;
         6'b100010, 6'b100011: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b100111: return 4'b1100;
         6'b101010, 6'b101011: return 4'b0111;
         6'b000000: return 4'b1001;
         6'b000010: return 4'b1010;
         6'b001000, 6'b010000, 6'b010010: return 4'b0011;
         default: return 4'b0000;
      endcase
   endfunction

   // Updates exp_hi/exp_lo and returns the expected done cycle counted from the start edge.
   task automatic model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv, output int lat);
      longint sa, sb, sq, sr;
      logic [63:0] p, q, r;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      lat = 33;
      if (f[1] == 1'b0) begin
         if (f[0] == 1'b0) p = 64'(sa * sb);
         else              p = {32'd0, av} * {32'd0, bv};
         exp_hi = p[63:32];
         exp_lo = p[31:0];
      end else begin
`ifdef MULDIV_DIV_EN
         if (bv == 32'd0) begin
            lat = 1;
            exp_lo = 32'hFFFF_FFFF;
            exp_hi = av;
         end else if (f[0] == 1'b0) begin
            sq = sa / sb;
            sr = sa % sb;
            q = 64'(sq);
            r = 64'(sr);
            exp_lo = q[31:0];
            exp_hi = r[31:0];
         end else begin
            exp_lo = av / bv;
            exp_hi = av % bv;
         end
`else
         lat = 1;
`endif
      end
   endtask

   // Issue one muldiv; hold MFLO upstream while busy; optionally present a MULTU in the done cycle.
   task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv, input bit chain);
      int lat, cyc;
      model(f, av, bv, lat);
      start = 1'b1; op = 2'b10; funct = f; a = av; b = bv;
      #1;
      if (stall !== 1'b0) begin n_err++; $display("FAIL issue_stall f=%b got=%b want=0", f, stall); end
      n_vec++;
      @(posedge clock); #1;
      funct = MFLO; a = $urandom; b = $urandom;
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
         #1;
         if (stall !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL busy_stall cyc=%0d got stall=%b busy=%b want 1/1", cyc, stall, busy);
         end
         n_vec++;
         @(posedge clock); #1;
         cyc++;
      end
      if (cyc !== lat) begin n_err++; $display("FAIL latency f=%b got=%0d want=%0d", f, cyc, lat); end
      n_vec++;
      if (hi !== exp_hi || lo !== exp_lo) begin
         n_err++; $display("FAIL result f=%b a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", f, av, bv, hi, lo, exp_hi, exp_lo);
      end
      n_vec++;
      if (chain) begin
         funct = MULTU;
         #1;
         if (stall !== 1'b1) begin n_err++; $display("FAIL done_md_stall got=%b want=1", stall); end
      end else begin
         #1;
         if (stall !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL done_mf_stall got stall=%b busy=%b want 0/0", stall, busy);
         end
      end
      n_vec++;
      if (!chain) start = 1'b0;
      @(posedge clock); #1;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse got=%b want=0", done); end
      n_vec++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; op = 2'b10; funct = MULT; a = 32'd3; b = 32'd7;
      repeat (2) @(posedge clock);
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_err++; $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
      end
      n_vec++;
      reset = 1'b0; start = 1'b0;
      @(posedge clock); #1;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         n_err++; $display("FAIL reset_no_start got busy=%b stall=%b want 0/0", busy, stall);
      end
      n_vec++;
   endtask

   task automatic test_decode();
      logic [5:0] f;
      for (int o = 0; o < 4; o++) begin
         for (int i = 0; i < 64; i++) begin
            if (o != 2 && i > 3) continue;
            f = 6'(i);
            op = 2'(o); funct = f; start = 1'b0;
            #1;
            if (control !== ref_ctrl(2'(o), f)) begin
               n_err++; $display("FAIL decode op=%0d funct=%b got=%b want=%b", o, f, control, ref_ctrl(2'(o), f));
            end
            n_vec++;
         end
      end
   endtask

   task automatic test_directed();
      run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_op(MULT, -32'sd3, 32'd7, 1'b0);
      run_op(DIV, -32'sd7, 32'd2, 1'b0);
      run_op(DIVU, 32'h1234, 32'd0, 1'b0);
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0);
      run_op(MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_op(MULT, 32'd1000, -32'sd9, 1'b1);
      run_op(MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
   endtask

   task automatic test_reset_midop();
      int cyc;
      start = 1'b1; op = 2'b10; funct = MULT; a = 32'd12345; b = 32'd678;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_hi = 32'd0; exp_lo = 32'd0;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_err++; $display("FAIL midop_reset got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
      end
      n_vec++;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done === 1'b1) cyc++;
      end
      if (cyc !== 0) begin n_err++; $display("FAIL aborted_done got=%0d pulses want=0", cyc); end
      n_vec++;
      run_op(MULTU, 32'd5, 32'd6, 1'b0);
   endtask

   task automatic test_random();
      logic [5:0] f;
      logic [31:0] av, bv;
      for (int i = 0; i < 24; i++) begin
         f = MULT + 6'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: av = 32'h8000_0000;
            1: av = 32'hFFFF_FFFF;
            default: av = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: bv = 32'd0;
            1: bv = 32'hFFFF_FFFF;
            2: bv = 32'($urandom_range(1, 20));
            default: bv = $urandom;
         endcase
         run_op(f, av, bv, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
      @(posedge clock); #1;
      test_reset();
      test_decode();
      test_directed();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
